// File: rtl/shift_seq_if.sv
// ----------------------------------------------------------------------------
// shift_seq_if
// Bundles the command handshake and the shift-register control bus of
// shift_seq so the sequencer and whoever drives it share one connection.
//
// Signals (DATA_BITS is the index of the data MSB):
//   cmd_valid / cmd_ready      command handshake
//   cmd_load, cmd_dir,
//   cmd_amt[AMT_BITS-1:0],
//   cmd_fill, cmd_data[DATA_BITS:0]   command fields
//   abort                      synchronous cancel of the running command
//   S1, S0                     shift-register mode (00 hold, 01 right, 10 left, 11 load)
//   SR, SL                     serial-in bits for right / left shifts
//   D[DATA_BITS:0]             parallel load word
//   done                       one-cycle completion pulse
//   cmd_rot, q_lsb, q_msb      rotate request and register taps, present only
//                              when SHIFT_SEQ_ROTATE_EN is defined
//
// Modports: master = command source / shift-register side, slave = sequencer.
// ----------------------------------------------------------------------------
interface shift_seq_if #(
  parameter int DATA_BITS = 64,
  parameter int AMT_BITS  = 7
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_load;
  logic                cmd_dir;
  logic [AMT_BITS-1:0] cmd_amt;
  logic                cmd_fill;
  logic [DATA_BITS:0]  cmd_data;
  logic                abort;
  logic                S1;
  logic                S0;
  logic                SR;
  logic                SL;
  logic [DATA_BITS:0]  D;
  logic                done;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic                cmd_rot;
  logic                q_lsb;
  logic                q_msb;
`endif

  modport master (
    output cmd_valid, cmd_load, cmd_dir, cmd_amt, cmd_fill, cmd_data, abort,
`ifdef SHIFT_SEQ_ROTATE_EN
    output cmd_rot, q_lsb, q_msb,
`endif
    input  cmd_ready, S1, S0, SR, SL, D, done
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_dir, cmd_amt, cmd_fill, cmd_data, abort,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  cmd_rot, q_lsb, q_msb,
`endif
    output cmd_ready, S1, S0, SR, SL, D, done
  );
endinterface

// File: rtl/shift_seq.sv
// ----------------------------------------------------------------------------
// shift_seq
// Sequencer that drives an external universal shift register. A command may
// parallel-load a word, then performs a number of single-bit shifts in one
// direction with a serial fill bit, then pulses done.
//
// Ports:
//   clk    single clock, all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    shift_seq_if.slave: command handshake in, shift-register controls out
//
// Optional feature: define SHIFT_SEQ_ROTATE_EN to add cmd_rot/q_lsb/q_msb.
// With cmd_rot captured high, SR follows q_lsb and SL follows q_msb every
// active cycle so the register rotates instead of shifting in cmd_fill.
// Without the macro SR and SL always carry the captured fill bit.
// ----------------------------------------------------------------------------
module shift_seq #(
  parameter int DATA_BITS = 64,
  parameter int AMT_BITS  = 7
) (
  input logic        clk,
  input logic        rst_n,
  shift_seq_if.slave bus
);

  // Longest meaningful shift: every bit of the word replaced once.
  localparam int MaxAmt = DATA_BITS + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t              r_state;
  logic [AMT_BITS-1:0] r_count;
  logic                r_dir;
  logic                r_fill;
  logic                r_ready;
  logic                r_s1;
  logic                r_s0;
  logic                r_sr;
  logic                r_sl;
  logic                r_done;
  logic [DATA_BITS:0]  r_d;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic                r_rot;
`endif

  logic                w_accept;
  logic [AMT_BITS-1:0] w_amtSat;
  logic                w_srAccept;
  logic                w_slAccept;
  logic                w_srRun;
  logic                w_slRun;

  // Handshake and amount saturation. cmd_ready is only ever high in IDLE, so
  // it alone qualifies acceptance. Amounts beyond the word width are clipped
  // because extra shifts would only repeat the fill bit.
  assign w_accept = bus.cmd_valid && r_ready;
  assign w_amtSat = (int'(bus.cmd_amt) > MaxAmt) ? AMT_BITS'(MaxAmt) : bus.cmd_amt;

  // Serial-in selection. At acceptance the incoming command fields are used;
  // while the command runs the captured fields are used. In rotate mode both
  // serial inputs track the register taps live; the shift direction decides
  // which of the two the register actually consumes.
`ifdef SHIFT_SEQ_ROTATE_EN
  assign w_srAccept = bus.cmd_rot ? bus.q_lsb : bus.cmd_fill;
  assign w_slAccept = bus.cmd_rot ? bus.q_msb : bus.cmd_fill;
  assign w_srRun    = r_rot ? bus.q_lsb : r_fill;
  assign w_slRun    = r_rot ? bus.q_msb : r_fill;
`else
  assign w_srAccept = bus.cmd_fill;
  assign w_slAccept = bus.cmd_fill;
  assign w_srRun    = r_fill;
  assign w_slRun    = r_fill;
`endif

  // Main sequencer. Every output is a register written on the same edge that
  // enters the state it belongs to, so outputs line up with the state without
  // a cycle of lag. The down-counter is loaded with the saturated amount at
  // acceptance and carried through LOAD; SHIFT leaves when it reaches one.
  // abort is only examined in LOAD and SHIFT, ahead of the counter test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_dir   <= 1'b0;
      r_fill  <= 1'b0;
      r_ready <= 1'b0;
      r_s1    <= 1'b0;
      r_s0    <= 1'b0;
      r_sr    <= 1'b0;
      r_sl    <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
      r_rot   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready <= 1'b0;
            r_dir   <= bus.cmd_dir;
            r_fill  <= bus.cmd_fill;
            r_count <= w_amtSat;
            r_sr    <= w_srAccept;
            r_sl    <= w_slAccept;
`ifdef SHIFT_SEQ_ROTATE_EN
            r_rot   <= bus.cmd_rot;
`endif
            if (bus.cmd_load) begin
              r_state <= LOAD;
              r_s1    <= 1'b1;
              r_s0    <= 1'b1;
              r_d     <= bus.cmd_data;
            end else if (w_amtSat != '0) begin
              r_state <= SHIFT;
              r_s1    <= bus.cmd_dir;
              r_s0    <= ~bus.cmd_dir;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_s1    <= 1'b0;
              r_s0    <= 1'b0;
            end
          end
        end

        LOAD: begin
          r_sr <= w_srRun;
          r_sl <= w_slRun;
          if (bus.abort) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_count <= '0;
            r_s1    <= 1'b0;
            r_s0    <= 1'b0;
          end else if (r_count != '0) begin
            r_state <= SHIFT;
            r_s1    <= r_dir;
            r_s0    <= ~r_dir;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_s1    <= 1'b0;
            r_s0    <= 1'b0;
          end
        end

        SHIFT: begin
          r_sr <= w_srRun;
          r_sl <= w_slRun;
          if (bus.abort) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_count <= '0;
            r_s1    <= 1'b0;
            r_s0    <= 1'b0;
          end else if (r_count == AMT_BITS'(1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_count <= '0;
            r_s1    <= 1'b0;
            r_s0    <= 1'b0;
          end else begin
            r_count <= r_count - AMT_BITS'(1);
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_s1    <= 1'b0;
          r_s0    <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_s1    <= 1'b0;
          r_s0    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_ready;
  assign bus.S1        = r_s1;
  assign bus.S0        = r_s0;
  assign bus.SR        = r_sr;
  assign bus.SL        = r_sl;
  assign bus.D         = r_d;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_shift_seq.sv
// ----------------------------------------------------------------------------
// tb_shift_seq
// Self-checking bench for shift_seq. Table-driven commands push their
// expected per-cycle outputs into a scoreboard queue when driven; the queue
// is popped and compared on falling edges. Hand-written sequences cover
// reset, abort and (with SHIFT_SEQ_ROTATE_EN) rotate.
// ----------------------------------------------------------------------------
module tb_shift_seq;

  localparam int DataBits = 64;
  localparam int AmtBits  = 7;
  localparam int MaxAmt   = DataBits + 1;

  typedef struct packed {
    logic              s1;
    logic              s0;
    logic              sr;
    logic              sl;
    logic              done;
    logic              ready;
    logic [DataBits:0] d;
  } outRec_t;

  typedef struct {
    logic              load;
    logic              dir;
    logic [AmtBits-1:0] amt;
    logic              fill;
    logic [DataBits:0] data;
    int                expShifts;
    int                expLatency;
  } vec_t;

  logic clk;
  logic rst_n;

  shift_seq_if #(.DATA_BITS(DataBits), .AMT_BITS(AmtBits)) bus ();

  shift_seq #(.DATA_BITS(DataBits), .AMT_BITS(AmtBits)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  outRec_t           expQ[$];
  vec_t              vecs[8];
  int                checks   = 0;
  int                failures = 0;
  logic [DataBits:0] lastD    = '0;

  // Compares every observable output against one expected record.
  task automatic checkOutput(input string name, input outRec_t exp);
    outRec_t act;
    act.s1    = bus.S1;
    act.s0    = bus.S0;
    act.sr    = bus.SR;
    act.sl    = bus.SL;
    act.done  = bus.done;
    act.ready = bus.cmd_ready;
    act.d     = bus.D;
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got s=%b%b sr=%b sl=%b done=%b rdy=%b d=%h, expected s=%b%b sr=%b sl=%b done=%b rdy=%b d=%h",
               name, act.s1, act.s0, act.sr, act.sl, act.done, act.ready, act.d,
               exp.s1, exp.s0, exp.sr, exp.sl, exp.done, exp.ready, exp.d);
    end
  endtask

  // Waits (bounded) for cmd_ready on a falling edge, then offers one command
  // for exactly one rising edge.
  task automatic driveCommand(input logic load, input logic dir, input logic [AmtBits-1:0] amt,
                              input logic fill, input logic [DataBits:0] data);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("[TB] FAIL ready_wait: got cmd_ready=%b after %0d cycles, expected 1", bus.cmd_ready, n);
    end
    bus.cmd_load  = load;
    bus.cmd_dir   = dir;
    bus.cmd_amt   = amt;
    bus.cmd_fill  = fill;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Scoreboard model: pushes the expected output of each cycle of a command,
  // from the first cycle after acceptance through the return to IDLE.
  task automatic applyStimulus(input logic load, input logic dir, input logic [AmtBits-1:0] amt,
                               input logic fill, input logic [DataBits:0] data, input int shifts);
    if (load) begin
      lastD = data;
      expQ.push_back('{1'b1, 1'b1, fill, fill, 1'b0, 1'b0, lastD});
    end
    for (int k = 0; k < shifts; k++)
      expQ.push_back('{dir, ~dir, fill, fill, 1'b0, 1'b0, lastD});
    expQ.push_back('{1'b0, 1'b0, fill, fill, 1'b1, 1'b0, lastD});
    expQ.push_back('{1'b0, 1'b0, fill, fill, 1'b0, 1'b1, lastD});
    driveCommand(load, dir, amt, fill, data);
  endtask

  // Pops and compares one record per cycle, and checks when done appeared.
  task automatic drainQueue(input string name, input int expLatency);
    int      cyc    = 0;
    int      doneAt = -1;
    outRec_t exp;
    while (expQ.size() > 0) begin
      @(negedge clk);
      cyc++;
      exp = expQ.pop_front();
      checkOutput(name, exp);
      if (bus.done === 1'b1 && doneAt < 0) doneAt = cyc;
    end
    checks++;
    if (doneAt != expLatency) begin
      failures++;
      $display("[TB] FAIL %s_latency: got done at cycle %0d, expected cycle %0d", name, doneAt, expLatency);
    end
  endtask

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test by time %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AmtBits-1:0] rAmt;
    logic [DataBits:0]  rData;
    logic               rLoad;
    logic               rDir;
    logic               rFill;
    int                 rShifts;

    vecs[0] = '{1'b1, 1'b1, 7'd3,   1'b0, 65'h1_0000_0000_0000_0001, 3,  5};
    vecs[1] = '{1'b0, 1'b0, 7'd0,   1'b1, 65'h0,                     0,  1};
    vecs[2] = '{1'b0, 1'b0, 7'd127, 1'b1, 65'h0,                     65, 66};
    vecs[3] = '{1'b1, 1'b0, 7'd0,   1'b0, 65'h0_DEAD_BEEF_0123_4567, 0,  2};
    vecs[4] = '{1'b0, 1'b1, 7'd65,  1'b0, 65'h0,                     65, 66};
    vecs[5] = '{1'b0, 1'b1, 7'd66,  1'b1, 65'h0,                     65, 66};
    vecs[6] = '{1'b1, 1'b0, 7'd1,   1'b1, 65'h1_FFFF_0000_FFFF_0000, 1,  3};
    vecs[7] = '{1'b0, 1'b0, 7'd64,  1'b0, 65'h0,                     64, 65};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_amt   = '0;
    bus.cmd_fill  = 1'b0;
    bus.cmd_data  = '0;
    bus.abort     = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
    bus.cmd_rot   = 1'b0;
    bus.q_lsb     = 1'b0;
    bus.q_msb     = 1'b0;
`endif

    // Reset state, and cmd_ready only after the first edge past release.
    #1 checkOutput("reset_state", '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("reset_release", '0);
    @(negedge clk);
    checkOutput("ready_after_reset", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0});

    // Table-driven commands.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].load, vecs[i].dir, vecs[i].amt, vecs[i].fill, vecs[i].data, vecs[i].expShifts);
      drainQueue($sformatf("vec%0d", i), vecs[i].expLatency);
    end

    // A few random commands checked against the saturating model.
    for (int i = 0; i < 4; i++) begin
      rAmt          = AmtBits'($urandom_range(127, 0));
      rLoad         = 1'($urandom_range(1, 0));
      rDir          = 1'($urandom_range(1, 0));
      rFill         = 1'($urandom_range(1, 0));
      rData[31:0]   = $urandom;
      rData[63:32]  = $urandom;
      rData[64]     = 1'($urandom_range(1, 0));
      rShifts       = (int'(rAmt) > MaxAmt) ? MaxAmt : int'(rAmt);
      applyStimulus(rLoad, rDir, rAmt, rFill, rData, rShifts);
      drainQueue($sformatf("rand%0d", i), int'(rLoad) + rShifts + 1);
    end

    // Abort on the 4th SHIFT cycle: back to IDLE, no done.
    driveCommand(1'b0, 1'b0, 7'd10, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("abort_shift", '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lastD});
    end
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort_idle", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lastD});
    end

    // Abort in LOAD drops the command; D keeps the word that was loaded.
    driveCommand(1'b1, 1'b1, 7'd5, 1'b1, 65'h0_1234_5678_9ABC_DEF0);
    lastD = 65'h0_1234_5678_9ABC_DEF0;
    @(negedge clk);
    checkOutput("abort_load", '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, lastD});
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_load_idle", '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, lastD});

    // abort held through IDLE and DONE is ignored.
    bus.abort = 1'b1;
    driveCommand(1'b0, 1'b0, 7'd0, 1'b0, '0);
    @(negedge clk);
    checkOutput("abort_in_done", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, lastD});
    @(negedge clk);
    checkOutput("abort_after_done", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lastD});
    bus.abort = 1'b0;

`ifdef SHIFT_SEQ_ROTATE_EN
    // Rotate right: SR follows q_lsb each SHIFT cycle, fill ignored.
    bus.cmd_rot = 1'b1;
    bus.q_lsb   = 1'b1;
    bus.q_msb   = 1'b0;
    driveCommand(1'b0, 1'b0, 7'd2, 1'b1, '0);
    @(negedge clk);
    checkOutput("rotate_sr1", '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, lastD});
    bus.q_lsb = 1'b0;
    @(negedge clk);
    checkOutput("rotate_sr0", '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lastD});
    @(negedge clk);
    checkOutput("rotate_done", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, lastD});
    bus.cmd_rot = 1'b0;
    @(negedge clk);
`endif

    // Reset asserted mid-SHIFT clears everything at once.
    driveCommand(1'b0, 1'b1, 7'd20, 1'b1, '0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("pre_reset_shift", '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, lastD});
    end
    rst_n = 1'b0;
    lastD = '0;
    #1 checkOutput("reset_mid_shift", '0);
    @(posedge clk);
    #1 checkOutput("reset_held", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("reset_mid_release", '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("ready_no_done", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter DATA_BITS, default 64, index of the data MSB; data words are DATA_BITS+1 bits.
REQ-002 Parameter AMT_BITS, default 7, width of the shift-amount field.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_load  input  1  parallel-load cmd_data before shifting.
REQ-008 cmd_dir  input  1  shift direction: 0 = right, 1 = left.
REQ-009 cmd_amt  input  AMT_BITS  number of single-bit shifts.
REQ-010 cmd_fill  input  1  serial fill bit.
REQ-011 cmd_data  input  DATA_BITS+1  parallel load word.
REQ-012 abort  input  1  synchronous command cancel.
REQ-013 S1, S0  output  1 each  shift-register mode: 00 hold, 01 right, 10 left, 11 load.
REQ-014 SR, SL  output  1 each  serial-in for right shift (enters MSB) and left shift (enters LSB).
REQ-015 D  output  DATA_BITS+1  parallel load word to the shift register.
REQ-016 done  output  1  one-cycle pulse at command completion.

Function
REQ-017 States: IDLE, LOAD, SHIFT, DONE; all outputs are registered.
REQ-018 cmd_ready is 1 only in IDLE; a command is accepted on a posedge with cmd_valid && cmd_ready, and all fields are captured at that edge.
REQ-019 Accept transitions: cmd_load=1 -> LOAD; else cmd_amt!=0 -> SHIFT; else -> DONE.
REQ-020 LOAD lasts exactly one cycle with {S1,S0}=11 and D=captured cmd_data, then goes to SHIFT if amt!=0, else to DONE.
REQ-021 SHIFT lasts exactly amt cycles with {S1,S0}=01 (dir=0) or 10 (dir=1), tracked by a down-counter, then goes to DONE.
REQ-022 cmd_amt values above DATA_BITS+1 saturate to DATA_BITS+1.
REQ-023 DONE lasts one cycle with done=1 and {S1,S0}=00, then goes to IDLE.
REQ-024 In IDLE and DONE, {S1,S0}=00; D holds its last loaded value.
REQ-025 Latency from the accept edge to done high is (cmd_load + amt + 1) cycles.
REQ-026 SR and SL both equal the captured fill bit for the whole command (see REQ-031 for the rotate exception).
REQ-027 abort=1 in LOAD or SHIFT -> IDLE at the next edge with {S1,S0}=00 and no done pulse; abort in IDLE or DONE is ignored.
REQ-028 abort has priority over counter expiry on the same edge.
REQ-029 There is no back-to-back acceptance: a new command is accepted no earlier than the cycle after DONE.

Reset
REQ-030 While rst_n=0, independent of clk: state=IDLE, counter=0, {S1,S0}=00, SR=SL=0, D=0, done=0, cmd_ready=0; cmd_ready rises at the first posedge after rst_n=1, and reset asserted mid-command drops the command with no done pulse.

Configuration
REQ-031 Rotate support is controlled by the macro SHIFT_SEQ_ROTATE_EN.
- Defined: the block adds inputs cmd_rot (1 bit), q_lsb (1 bit) and q_msb (1 bit).
- Defined, cmd_rot=1 captured: SR=q_lsb when dir=0, and SL=q_msb when dir=1; SR/SL follow the taps each SHIFT cycle and cmd_fill is ignored.
- Not defined: these ports do not exist and SR=SL=fill always.

Verification
REQ-032 Reset: rst_n low mid-SHIFT -> all outputs take their REQ-030 values immediately; cmd_ready=1 one edge after release.
REQ-033 Load+shift: cmd_load=1, data=0x1_0000_0000_0000_0001, dir=1, amt=3, fill=0 -> 1 cycle S=11 with D=data, then 3 cycles S=10, done on the 5th cycle after accept.
REQ-034 Zero amount: cmd_load=0, amt=0 -> done in the cycle after accept; S stays 00 throughout.
REQ-035 Saturation: amt=127, dir=0, fill=1 -> exactly 65 cycles of S=01 with SR=1, then done.
REQ-036 Abort: amt=10 with abort on the 4th SHIFT cycle -> 4 cycles of S=01, then S=00 and cmd_ready=1 at the next edge, and done never asserts.
REQ-037 Rotate (SHIFT_SEQ_ROTATE_EN defined): cmd_rot=1, dir=0, amt=2, q_lsb toggled 1 then 0 -> SR=1 then 0 on the two SHIFT cycles.
